// File: rtl/led_pattern_engine.sv
// LED pattern generator with an internal step divider: rotate left/right, flash, bounce, count, hold.
// Latency: led and step are registered and update on the tick edge; mode change and reset take effect on the next edge.
// Backpressure: none; enable=0 freezes the divider and the pattern in place.
module led_pattern_engine #(
    parameter int LED_WIDTH   = 16,
    parameter int CLK_FREQ_HZ = 5000000,
    parameter int STEP_HZ     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           mode,
    output logic [LED_WIDTH-1:0] led,
    output logic                 step
);
    localparam int DIV = CLK_FREQ_HZ / STEP_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] M_ROL    = 3'd0;
    localparam logic [2:0] M_ROR    = 3'd1;
    localparam logic [2:0] M_FLASH  = 3'd2;
    localparam logic [2:0] M_BOUNCE = 3'd3;
    localparam logic [2:0] M_COUNT  = 3'd4;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("led_pattern_engine: CLK_FREQ_HZ/STEP_HZ must be >= 2");
        end
        if (LED_WIDTH < 2 || LED_WIDTH > 32) begin : g_bad_width
            $error("led_pattern_engine: LED_WIDTH must be in 2..32");
        end
    endgenerate

    localparam logic [LED_WIDTH-1:0] ONE_HOT_LSB = {{(LED_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LED_WIDTH-1:0] ONE_HOT_MSB = {1'b1, {(LED_WIDTH-1){1'b0}}};

    logic [CW-1:0]        counter;
    logic [2:0]           mode_q;
    logic                 dir;
    logic                 tick;
    logic [LED_WIDTH-1:0] nxt_led;
    logic                 nxt_dir;

    // Modes 5-7 have no seed, so the current pattern is kept.
    function automatic logic [LED_WIDTH-1:0] seed(input logic [2:0] m, input logic [LED_WIDTH-1:0] cur);
        case (m)
            M_ROL, M_BOUNCE: seed = ONE_HOT_LSB;
            M_ROR:           seed = ONE_HOT_MSB;
            M_FLASH, M_COUNT: seed = '0;
            default:         seed = cur;
        endcase
    endfunction

    assign tick = enable && (counter == CW'(DIV - 1));

    always_comb begin
        nxt_led = led;
        nxt_dir = dir;
        case (mode_q)
            M_ROL:   nxt_led = {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
            M_ROR:   nxt_led = {led[0], led[LED_WIDTH-1:1]};
            M_FLASH: nxt_led = ~led;
            M_BOUNCE: begin
                if (!dir) begin
                    nxt_led = led << 1;
                    if (nxt_led[LED_WIDTH-1]) nxt_dir = 1'b1;
                end else begin
                    nxt_led = led >> 1;
                    if (nxt_led[0]) nxt_dir = 1'b0;
                end
            end
            M_COUNT: nxt_led = led + ONE_HOT_LSB;
            default: nxt_led = led;
        endcase
    end

    // Reset and mode change share the reseed path; a mode change drops a coincident tick.
    always_ff @(posedge clk) begin
        if (reset || (mode != mode_q)) begin
            counter <= '0;
            mode_q  <= mode;
            dir     <= 1'b0;
            step    <= 1'b0;
            led     <= seed(mode, led);
        end else if (tick) begin
            counter <= '0;
            step    <= 1'b1;
            led     <= nxt_led;
            dir     <= nxt_dir;
        end else begin
            step <= 1'b0;
            if (enable) counter <= counter + CW'(1);
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (LED_WIDTH=4, DIV=4): stimulus queues expected steps, a monitor checks them.
module tb_led_pattern_engine;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] mode;
    logic [3:0] led;
    logic       step;

    led_pattern_engine #(.LED_WIDTH(4), .CLK_FREQ_HZ(4), .STEP_HZ(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .led(led), .step(step)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] led;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_step(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.led = v;
        q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every step pulse must match the next queued (cycle, led) pair.
    initial forever begin
        @(negedge clk);
        if (step === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_step", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("step_cycle", 32'(cyc), 32'(e.cyc));
                check("step_led", {28'd0, led}, {28'd0, e.led});
            end
        end
    end

    int z;
    logic [3:0] bounce_seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 3'd0;
        @(negedge clk);
        check("reset_led", {28'd0, led}, 32'h1);
        check("reset_step", {31'd0, step}, 32'h0);
        reset = 1'b0;
        z = cyc;

        // Rotate left
        expect_step(z + 4, 4'b0010);
        expect_step(z + 8, 4'b0100);
        expect_step(z + 12, 4'b1000);
        expect_step(z + 16, 4'b0001);
        wait_to(z + 16);

        // Bounce
        mode = 3'd3;
        wait_to(z + 17);
        check("bounce_seed", {28'd0, led}, 32'h1);
        z = cyc;
        for (int k = 0; k < 8; k++) expect_step(z + 4 * (k + 1), bounce_seq[k]);
        wait_to(z + 32);

        // Binary count with wrap
        mode = 3'd4;
        wait_to(z + 33);
        check("count_seed", {28'd0, led}, 32'h0);
        z = cyc;
        for (int k = 1; k <= 17; k++) expect_step(z + 4 * k, 4'(k));
        wait_to(z + 68);

        // Mode change coincident with a tick: tick dropped, flash seeded
        mode = 3'd0;
        wait_to(z + 69);
        z = cyc;
        expect_step(z + 4, 4'b0010);
        wait_to(z + 7);
        mode = 3'd2;
        wait_to(z + 8);
        check("chg_led", {28'd0, led}, 32'h0);
        check("chg_step", {31'd0, step}, 32'h0);
        z = cyc;
        expect_step(z + 4, 4'b1111);
        expect_step(z + 8, 4'b0000);

        // Freeze with counter=2, then resume: step two cycles after re-enable
        wait_to(z + 10);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("freeze_led", {28'd0, led}, 32'h0);
        end
        enable = 1'b1;
        expect_step(z + 22, 4'b1111);
        wait_to(z + 22);

        // Reset at counter=3 in mode 1 beats the tick
        mode = 3'd1;
        wait_to(z + 23);
        check("ror_seed", {28'd0, led}, 32'h8);
        z = cyc;
        expect_step(z + 4, 4'b0100);
        wait_to(z + 7);
        reset = 1'b1;
        wait_to(z + 8);
        check("midreset_led", {28'd0, led}, 32'h8);
        check("midreset_step", {31'd0, step}, 32'h0);
        reset = 1'b0;
        expect_step(z + 12, 4'b0100);
        wait_to(z + 12);

        // Hold mode keeps the pattern while steps still pulse
        mode = 3'd5;
        wait_to(z + 13);
        check("hold_led", {28'd0, led}, 32'h4);
        z = cyc;
        expect_step(z + 4, 4'b0100);
        expect_step(z + 8, 4'b0100);
        wait_to(z + 10);

        check("pending_steps", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised LED pattern generator that succeeds the fixed shift/flash/mux arrangement with a single block. It has an internal step-rate divider and five selectable patterns: rotate left, rotate right, flash, bounce and binary count. It runs entirely on the board master clock with no derived clocks. It drives the board LED bank directly from the top level.

Parameters:
LED_WIDTH, 16, number of LED outputs; legal range 2..32.
CLK_FREQ_HZ, 5000000, frequency of clk in Hz.
STEP_HZ, 2, pattern step rate in Hz.
DIV, CLK_FREQ_HZ/STEP_HZ (derived localparam), clk cycles per step. Must be >= 2; elaboration error otherwise.

Ports:
clk  input  1  master clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  1 = divider runs and steps occur; 0 = freeze divider and pattern.
mode  input  3  pattern select: 0 rotate left, 1 rotate right, 2 flash, 3 bounce, 4 count, 5-7 hold.
led  output  LED_WIDTH  registered pattern output.
step  output  1  registered one-cycle pulse, high in the cycle led updates on a step.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port named reset. Reset is sampled only on a rising clk edge. Reset overrides all other inputs.
- State: divider counter (clog2(DIV) bits), mode_q (3 bits), dir (0 = up/left, 1 = down/right), led register.
- Reset values:
  - counter = 0, mode_q = mode, dir = 0, step = 0.
  - led = seed(mode).
- Seeds:
  - mode 0: 0..01
  - mode 1: 10..0
  - mode 2: all 0
  - mode 3: 0..01
  - mode 4: all 0
  - modes 5-7: led keeps its current value.
- Divider:
  - When enable=1, counter increments each cycle and wraps DIV-1 -> 0.
  - An internal tick occurs in the cycle counter == DIV-1 and enable=1.
  - When enable=0, counter holds and no tick occurs.
- Step: on a tick, led takes the next value on that edge and step=1 for exactly that one cycle; step=0 otherwise. First step comes DIV cycles after reset release when enable stays 1.
- Next-value rules, applied only on a step:
  - mode 0: rotate left by 1; MSB wraps to LSB.
  - mode 1: rotate right by 1; LSB wraps to MSB.
  - mode 2: bitwise invert (all0 <-> all1).
  - mode 3: single bit walks. If dir=0, shift left; when the result has the MSB set, dir becomes 1. If dir=1, shift right; when the result has the LSB set, dir becomes 0. Width 4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - mode 4: led = led + 1, modulo 2^LED_WIDTH (all1 -> all0).
  - modes 5-7: led unchanged; step still pulses.
- Mode change: detected when mode != mode_q, regardless of enable.
  - On that edge: mode_q = mode, led = seed(mode), dir = 0, counter = 0, step = 0.
  - Mode change takes priority over a coincident tick; that tick is dropped.
  - For a change into modes 5-7, led holds its value; dir and counter still clear.
- Reset asserted mid-step or mid-count: same-edge return to reset values; no step pulse.
- No combinational path from inputs to led or step.

Test Plan:
- Params LED_WIDTH=4, CLK_FREQ_HZ=4, STEP_HZ=1 (DIV=4) unless stated.
- Reset with mode=0, enable=1 -> led=0001, step=0. Steps every 4 cycles give 0010, 0100, 1000, 0001. step is high exactly 1 cycle in 4.
- mode=3 for 8 steps -> led = 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100; dir flips at 1000 and 0001.
- mode=4 for 17 steps -> led counts 0001..1111, then 0000, then 0001; wraps at the 16th step.
- Mode 0 -> 2 switch in the same cycle as a tick -> next led=0000, step stays 0, counter=0. Next step arrives 4 cycles later with led=1111.
- enable=0 held for 10 cycles mid-count -> led and counter frozen, step=0. After re-enable the step comes after the remaining count: e.g. counter=2 at freeze gives a step 2 cycles later.
- reset held 1 cycle at counter=3, mode=1 -> led=1000, counter=0, step=0 on that edge. Next step 4 cycles after reset drops gives led=0100.
